// File: rtl/i2c_master.sv
// Byte-level I2C bus master: START / WRITE / READ / STOP, one command in and one response out over valid/ready.
// Latency 4*DIV+1 (START/STOP) or 36*DIV+1 (byte) cycles plus SCL stretching; cmd_ready is low while a command runs.
module i2c_master #(
  parameter int DIV = 63
) (
  input  logic       CLK_I,
  input  logic       RST_I,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [7:0] cmd_data,
  input  logic       cmd_nack,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       rsp_nack,
  output logic       rsp_arb,
  output logic       rsp_err,
  output logic       bus_owned,
  output logic       scl_oe,
  input  logic       scl_i,
  output logic       sda_oe,
  input  logic       sda_i
);

  typedef enum logic [2:0] {IDLE, START, BIT, STOP, RESP} state_t;

  localparam logic [1:0]  OP_START = 2'b00;
  localparam logic [1:0]  OP_WRITE = 2'b01;
  localparam logic [1:0]  OP_READ  = 2'b10;
  localparam logic [1:0]  OP_STOP  = 2'b11;
  localparam logic [15:0] QLAST    = 16'(DIV - 1);

  state_t      state, state_nxt;
  logic [15:0] qcnt;
  logic [1:0]  quarter;
  logic [3:0]  bitcnt;
  logic [1:0]  op;
  logic        nack_l;
  logic [7:0]  tx;
  logic [7:0]  rx;
  logic        ack_l;
  logic        err_l;
  logic        arb_l;

  logic active, stall, q_done, last_q, sample, arb_lost, next_bit;
  logic scl_nxt, sda_nxt;

  assign active = (state == START) || (state == BIT) || (state == STOP);
  // A released SCL that is still low belongs to a stretching target: freeze the quarter.
  assign stall  = active && !scl_oe && !scl_i;
  assign q_done = active && !stall && (qcnt == QLAST);
  assign last_q = q_done && (quarter == 2'd3);
  assign sample = (state == BIT) && (quarter == 2'd2) && q_done;

  // Lost only where we released SDA in a slot that is ours to drive (not the target's ACK or data).
  assign arb_lost = sample && !sda_oe && !sda_i &&
                    (((op == OP_WRITE) && (bitcnt != 4'd8)) || ((op == OP_READ) && (bitcnt == 4'd8)));

  always_comb begin
    if (bitcnt == 4'd7) next_bit = (op == OP_WRITE) ? 1'b1 : nack_l;
    else                next_bit = (op == OP_WRITE) ? tx[7] : 1'b1;
  end

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      state     <= IDLE;
      qcnt      <= '0;
      quarter   <= '0;
      bitcnt    <= '0;
      op        <= OP_START;
      nack_l    <= 1'b0;
      tx        <= '0;
      rx        <= '0;
      ack_l     <= 1'b0;
      err_l     <= 1'b0;
      arb_l     <= 1'b0;
      scl_oe    <= 1'b0;
      sda_oe    <= 1'b0;
      bus_owned <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_nack  <= 1'b0;
      rsp_arb   <= 1'b0;
      rsp_err   <= 1'b0;
    end else begin
      state     <= state_nxt;
      scl_oe    <= scl_nxt;
      sda_oe    <= sda_nxt;
      rsp_valid <= (state == RESP);

      if (state == IDLE) begin
        qcnt    <= '0;
        quarter <= '0;
        bitcnt  <= '0;
        if (cmd_valid) begin
          op     <= cmd_op;
          nack_l <= cmd_nack;
          tx     <= cmd_data;
          rx     <= '0;
          ack_l  <= 1'b0;
          arb_l  <= 1'b0;
          err_l  <= (cmd_op != OP_START) && !bus_owned;
        end
      end else if (active && !stall) begin
        if (qcnt == QLAST) begin
          qcnt    <= '0;
          quarter <= quarter + 2'd1;
          if ((state == BIT) && (quarter == 2'd3)) bitcnt <= bitcnt + 4'd1;
        end else begin
          qcnt <= qcnt + 16'd1;
        end
      end

      if (sample) begin
        if (bitcnt == 4'd8) begin
          ack_l <= sda_i;
        end else begin
          rx <= {rx[6:0], sda_i};
          tx <= {tx[6:0], 1'b0};
        end
      end

      if ((state == START) && last_q) bus_owned <= 1'b1;
      if ((state == STOP) && last_q)  bus_owned <= 1'b0;
      if (arb_lost) begin
        arb_l     <= 1'b1;
        bus_owned <= 1'b0;
      end

      if (state == RESP) begin
        rsp_err  <= err_l;
        rsp_arb  <= arb_l;
        rsp_nack <= (op == OP_WRITE) && !err_l && !arb_l && ack_l;
        rsp_data <= (((op == OP_READ) && !err_l) || arb_l) ? rx : 8'h00;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          if (cmd_op == OP_START)     state_nxt = START;
          else if (!bus_owned)        state_nxt = RESP;
          else if (cmd_op == OP_STOP) state_nxt = STOP;
          else                        state_nxt = BIT;
        end
      end
      START, STOP: if (last_q) state_nxt = RESP;
      BIT:         if (arb_lost || (last_q && (bitcnt == 4'd8))) state_nxt = RESP;
      RESP:        state_nxt = IDLE;
      default:     state_nxt = IDLE;
    endcase
  end

  // Line values are registered and change only on quarter boundaries; idle phases hold the bus as left.
  always_comb begin
    cmd_ready = (state == IDLE);
    scl_nxt   = scl_oe;
    sda_nxt   = sda_oe;
    if (state == IDLE) begin
      if (cmd_valid) begin
        case (state_nxt)
          START: sda_nxt = 1'b0;
          STOP: begin
            scl_nxt = 1'b1;
            sda_nxt = 1'b1;
          end
          BIT: begin
            scl_nxt = 1'b1;
            sda_nxt = (cmd_op == OP_WRITE) ? ~cmd_data[7] : 1'b0;
          end
          default: ;
        endcase
      end
    end else if (arb_lost) begin
      scl_nxt = 1'b0;
      sda_nxt = 1'b0;
    end else if (q_done) begin
      case (state)
        START: begin
          case (quarter)
            2'd0:    scl_nxt = 1'b0;
            2'd1:    sda_nxt = 1'b1;
            2'd2:    scl_nxt = 1'b1;
            default: ;
          endcase
        end
        STOP: begin
          case (quarter)
            2'd0:    scl_nxt = 1'b0;
            2'd1:    sda_nxt = 1'b0;
            default: ;
          endcase
        end
        BIT: begin
          case (quarter)
            2'd1: scl_nxt = 1'b0;
            2'd3: begin
              scl_nxt = 1'b1;
              if (bitcnt != 4'd8) sda_nxt = ~next_bit;
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_master.sv
// Directed bench for i2c_master at DIV=4 with an open-drain bus, a simple target and a clock-stretch/arbitration helper.
module tb_i2c_master;
  localparam int DIV = 4;
  localparam logic [1:0] OP_START = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] OP_STOP  = 2'b11;

  logic       CLK_I = 1'b0;
  logic       RST_I = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'b00;
  logic [7:0] cmd_data = 8'h00;
  logic       cmd_nack = 1'b0;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       rsp_nack;
  logic       rsp_arb;
  logic       rsp_err;
  logic       bus_owned;
  logic       scl_oe;
  logic       sda_oe;
  wire        scl_i;
  wire        sda_i;

  int checks = 0;
  int failures = 0;

  // Stimulus-side controls (written only by the main sequence)
  int         tgt_mode = 0;    // 0 silent, 1 ACK a write, 2 send rbyte
  logic [7:0] rbyte = 8'h00;
  logic       arb_sda = 1'b0;
  logic       stretch_en = 1'b0;
  int         issue_tok = 0;

  // Bus-monitor state (written only by the monitor)
  int         falls = 0;
  int         cur_slot = 0;
  int         stretch_cnt = 0;
  logic       stretch = 1'b0;
  logic       ack_drv = 1'b0;
  logic [8:0] cap = 9'h000;
  int         ncap = 0;

  logic tgt_sda;
  assign tgt_sda = ((tgt_mode == 1) && (cur_slot == 8)) ||
                   ((tgt_mode == 2) && (cur_slot < 8) && !rbyte[3'(7 - cur_slot)]);
  assign scl_i = ~(scl_oe | stretch);
  assign sda_i = ~(sda_oe | tgt_sda | arb_sda);

  i2c_master #(.DIV(DIV)) dut (
    .CLK_I(CLK_I), .RST_I(RST_I),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_nack(cmd_nack),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_nack(rsp_nack), .rsp_arb(rsp_arb), .rsp_err(rsp_err),
    .bus_owned(bus_owned), .scl_oe(scl_oe), .scl_i(scl_i), .sda_oe(sda_oe), .sda_i(sda_i)
  );

  always #5 CLK_I = ~CLK_I;

  // Tracks SCL slots, plays the target, stretches SCL on request and captures SDA at each SCL rise.
  initial begin
    logic prev_oe;
    logic prev_line;
    logic line;
    int   last_tok;
    prev_oe = 1'b0;
    prev_line = 1'b1;
    last_tok = 0;
    forever begin
      @(posedge CLK_I);
      #1;
      if (issue_tok != last_tok) begin
        last_tok = issue_tok;
        falls = 0;
        cur_slot = 0;
        ack_drv = 1'b0;
        cap = 9'h000;
        ncap = 0;
      end
      if (stretch_cnt > 0) begin
        stretch_cnt = stretch_cnt - 1;
        if (stretch_cnt == 0) stretch = 1'b0;
      end
      if (prev_oe && !scl_oe) begin
        falls = falls + 1;
        if (stretch_en && (falls == 3)) begin
          stretch = 1'b1;
          stretch_cnt = 20;
        end
      end
      if (!prev_oe && scl_oe) cur_slot = falls;
      if (cur_slot == 8) ack_drv = ack_drv | sda_oe;
      line = !scl_oe && !stretch;
      if (line && !prev_line) begin
        cap = {cap[7:0], sda_i};
        ncap = ncap + 1;
      end
      prev_line = line;
      prev_oe = scl_oe;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Issues one command, waits (bounded) for its response and returns the latency in cycles from acceptance.
  task automatic do_cmd(input string tag, input logic [1:0] op, input logic [7:0] d, input logic n,
                        output int lat, output logic oe_seen);
    @(posedge CLK_I);
    #2;
    check({tag, " ready_before"}, {31'd0, cmd_ready}, 32'd1);
    cmd_op = op;
    cmd_data = d;
    cmd_nack = n;
    cmd_valid = 1'b1;
    issue_tok = issue_tok + 1;
    @(posedge CLK_I);
    #2;
    cmd_valid = 1'b0;
    check({tag, " ready_drop"}, {31'd0, cmd_ready}, 32'd0);
    oe_seen = scl_oe | sda_oe;
    lat = 0;
    do begin
      @(posedge CLK_I);
      #2;
      lat++;
      oe_seen = oe_seen | scl_oe | sda_oe;
    end while (!rsp_valid && (lat < 2000));
    check({tag, " rsp_valid"}, {31'd0, rsp_valid}, 32'd1);
    check({tag, " ready_back"}, {31'd0, cmd_ready}, 32'd1);
  endtask

  initial begin
    int   lat;
    int   lat_plain;
    logic oe;
    logic seen;

    #3;
    check("rst scl_oe", {31'd0, scl_oe}, 32'd0);
    check("rst sda_oe", {31'd0, sda_oe}, 32'd0);
    check("rst cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("rst rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst rsp_data", {24'd0, rsp_data}, 32'd0);
    check("rst rsp_flags", {29'd0, rsp_nack, rsp_arb, rsp_err}, 32'd0);
    check("rst bus_owned", {31'd0, bus_owned}, 32'd0);
    repeat (2) @(posedge CLK_I);
    #2;
    RST_I = 1'b0;

    // START, WRITE 0xA5 with ACK, STOP
    do_cmd("start1", OP_START, 8'h00, 1'b0, lat, oe);
    check("start1 latency", lat, 4 * DIV + 1);
    check("start1 owned", {31'd0, bus_owned}, 32'd1);
    check("start1 lines held", {30'd0, scl_oe, sda_oe}, 32'd3);
    tgt_mode = 1;
    do_cmd("wr_a5", OP_WRITE, 8'hA5, 1'b0, lat, oe);
    check("wr_a5 latency", lat, 36 * DIV + 1);
    check("wr_a5 flags", {29'd0, rsp_nack, rsp_arb, rsp_err}, 32'd0);
    check("wr_a5 rsp_data", {24'd0, rsp_data}, 32'd0);
    check("wr_a5 bus bits", {23'd0, cap}, 32'h14A);
    check("wr_a5 rises", ncap, 9);
    check("wr_a5 owned", {31'd0, bus_owned}, 32'd1);
    tgt_mode = 0;
    do_cmd("stop1", OP_STOP, 8'h00, 1'b0, lat, oe);
    check("stop1 latency", lat, 4 * DIV + 1);
    check("stop1 owned", {31'd0, bus_owned}, 32'd0);
    check("stop1 lines", {30'd0, scl_oe, sda_oe}, 32'd0);

    // START, READ with NACK; target sends 0x3C
    do_cmd("start2", OP_START, 8'h00, 1'b0, lat, oe);
    rbyte = 8'h3C;
    tgt_mode = 2;
    do_cmd("rd_3c", OP_READ, 8'h00, 1'b1, lat, oe);
    check("rd_3c latency", lat, 36 * DIV + 1);
    check("rd_3c rsp_data", {24'd0, rsp_data}, 32'h3C);
    check("rd_3c rsp_nack", {31'd0, rsp_nack}, 32'd0);
    check("rd_3c master ack drive", {31'd0, ack_drv}, 32'd0);
    check("rd_3c bus bits", {23'd0, cap}, 32'h079);

    // WRITE 0xFF plain, then stretched by 20 cycles in the third slot
    tgt_mode = 1;
    do_cmd("wr_ff", OP_WRITE, 8'hFF, 1'b0, lat_plain, oe);
    check("wr_ff latency", lat_plain, 36 * DIV + 1);
    stretch_en = 1'b1;
    do_cmd("wr_ff_str", OP_WRITE, 8'hFF, 1'b0, lat, oe);
    stretch_en = 1'b0;
    check("wr_ff_str extra delay", lat - lat_plain, 20);
    check("wr_ff_str bus bits", {23'd0, cap}, 32'h1FE);
    check("wr_ff_str flags", {29'd0, rsp_nack, rsp_arb, rsp_err}, 32'd0);

    // WRITE 0x00 with a silent target: NACK reported
    tgt_mode = 0;
    do_cmd("wr_nack", OP_WRITE, 8'h00, 1'b0, lat, oe);
    check("wr_nack rsp_nack", {31'd0, rsp_nack}, 32'd1);
    check("wr_nack bus bits", {23'd0, cap}, 32'h001);

    // WRITE 0x80 while another master pulls SDA in the first slot
    arb_sda = 1'b1;
    do_cmd("arb", OP_WRITE, 8'h80, 1'b0, lat, oe);
    check("arb latency", lat, 3 * DIV + 1);
    check("arb rsp_arb", {31'd0, rsp_arb}, 32'd1);
    check("arb owned", {31'd0, bus_owned}, 32'd0);
    check("arb lines", {30'd0, scl_oe, sda_oe}, 32'd0);
    arb_sda = 1'b0;

    // WRITE while the bus is not owned
    do_cmd("illegal", OP_WRITE, 8'h55, 1'b0, lat, oe);
    check("illegal latency", lat, 1);
    check("illegal rsp_err", {31'd0, rsp_err}, 32'd1);
    check("illegal other fields", {22'd0, rsp_data, rsp_nack, rsp_arb}, 32'd0);
    check("illegal lines quiet", {31'd0, oe}, 32'd0);

    // Asynchronous reset in the middle of a READ
    do_cmd("start3", OP_START, 8'h00, 1'b0, lat, oe);
    @(posedge CLK_I);
    #2;
    cmd_op = OP_READ;
    cmd_nack = 1'b0;
    cmd_valid = 1'b1;
    issue_tok = issue_tok + 1;
    @(posedge CLK_I);
    #2;
    cmd_valid = 1'b0;
    repeat (32) @(posedge CLK_I);
    #2;
    check("midrd scl pulled", {31'd0, scl_oe}, 32'd1);
    #1;
    RST_I = 1'b1;
    #1;
    check("midrd async release", {30'd0, scl_oe, sda_oe}, 32'd0);
    repeat (2) @(posedge CLK_I);
    #2;
    RST_I = 1'b0;
    check("post_rst cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("post_rst owned", {31'd0, bus_owned}, 32'd0);
    seen = 1'b0;
    repeat (50) begin
      @(posedge CLK_I);
      #2;
      seen = seen | rsp_valid;
    end
    check("post_rst no rsp", {31'd0, seen}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/i2c_master.md
Name: i2c_master

Overview:
- Byte-level I2C bus master engine.
- It is the initiator counterpart to our existing I2C target: it drives SCL and generates START, STOP, byte writes and byte reads toward external I2C targets.
- It takes one command at a time over a valid/ready handshake and returns one response per command.
- It sits behind a Wishbone register/FIFO wrapper, which feeds commands and collects responses; the wrapper is not part of this block.

Parameters:
- DIV, 63: CLK_I cycles per SCL quarter-period. Legal range 2..65535; the default gives ~400 kHz at 100 MHz.

Ports:
- CLK_I  input  1  system clock.
- RST_I  input  1  reset, asynchronous, active-high.
- cmd_valid  input  1  a command is presented.
- cmd_ready  output  1  engine can accept a command.
- cmd_op  input  2  command code: 00 START (also repeated START), 01 WRITE, 10 READ, 11 STOP.
- cmd_data  input  8  byte to send on WRITE.
- cmd_nack  input  1  on READ, the master drives NACK (1) instead of ACK (0).
- rsp_valid  output  1  one-cycle pulse at command completion.
- rsp_data  output  8  byte read on READ; 0 for all other commands.
- rsp_nack  output  1  WRITE only: the sampled ACK bit (1 = target NACKed).
- rsp_arb  output  1  arbitration was lost during this command.
- rsp_err  output  1  command was illegal in the current bus state.
- bus_owned  output  1  high from START completion until STOP completion or arbitration loss.
- scl_oe  output  1  1 = pull SCL low, 0 = release.
- scl_i  input  1  sampled SCL pad.
- sda_oe  output  1  1 = pull SDA low, 0 = release.
- sda_i  input  1  sampled SDA pad.

Behaviour:
- Reset values: scl_oe=0, sda_oe=0, cmd_ready=1, rsp_valid=0, rsp_data=0, rsp_nack=0, rsp_arb=0, rsp_err=0, bus_owned=0, FSM=IDLE.
- Reset is asynchronous: both lines are released immediately, even mid-byte.
- Handshake and latency:
  - A command is accepted on the cycle cmd_valid & cmd_ready. cmd_ready drops the next cycle; cmd_op, cmd_data and cmd_nack are latched at acceptance.
  - rsp_valid pulses one cycle after the last quarter expires. cmd_ready reasserts in that same cycle.
  - rsp_* fields hold their value until the next rsp_valid.
- Quarter timer:
  - Counts DIV cycles per quarter.
  - In any quarter where SCL is released, the counter is held at 0 while scl_i==0 (clock stretching; no timeout).
- START (4 quarters):
  - Q0: sda_oe=0, scl_oe unchanged.
  - Q1: scl_oe=0 (stretch-wait).
  - Q2: sda_oe=1.
  - Q3: scl_oe=1.
  - Sets bus_owned.
  - Latency is 4*DIV+1 cycles without stretching.
- Bit slot (4 quarters; SCL is low at entry):
  - Q0: scl_oe=1, sda_oe=~bit.
  - Q1: hold.
  - Q2: scl_oe=0 (stretch-wait).
  - Q3: SCL high.
  - sda_i is sampled on the last cycle of Q2, after scl_i is seen high.
  - SCL is pulled low at the end of Q3.
- WRITE:
  - 8 data bits MSB first, then one ACK slot with SDA released.
  - rsp_nack = the sampled ACK bit.
  - 36*DIV+1 cycles.
- READ:
  - 8 slots with SDA released; samples are shifted in MSB first.
  - 9th slot drives cmd_nack.
  - rsp_data = the byte read.
- STOP (4 quarters):
  - Q0: scl_oe=1, sda_oe=1.
  - Q1: scl_oe=0 (stretch-wait).
  - Q2: sda_oe=0.
  - Q3: idle (bus-free time).
  - Clears bus_owned.
- Arbitration:
  - Applies in any WRITE data bit, or in the READ ACK slot driving 1, where the master released SDA but samples sda_i==0.
  - On loss: release both lines the next cycle, abort the rest of the command, return to IDLE.
  - Response: rsp_valid with rsp_arb=1 (rsp_data holds bits shifted so far), bus_owned=0.
- Illegal commands:
  - WRITE, READ or STOP while bus_owned==0 produces no bus activity.
  - rsp_valid comes 1 cycle after acceptance, with rsp_err=1 and other fields 0.
  - START while owned is legal and performs a repeated START.
- Line holding: between commands while owned, SCL stays pulled low and SDA keeps its last value, so the bus is held.
- States: IDLE, START, BIT, STOP, RESP.

Test Plan:
- DIV=4. START, WRITE 0xA5 (target ACKs), STOP:
  - SDA during the SCL-high quarters reads 1,0,1,0,0,1,0,1.
  - WRITE rsp_valid arrives 145 cycles after acceptance, with rsp_nack=0 and rsp_err=0.
  - bus_owned goes 1 then 0.
- START, READ with cmd_nack=1, target drives 0x3C:
  - rsp_data=0x3C.
  - Master leaves SDA released in the 9th slot.
  - rsp_nack=0.
- Target holds SCL low 20 cycles in bit 3 of a WRITE 0xFF:
  - Timer freezes.
  - rsp_valid is delayed by exactly 20 cycles versus the unstretched run.
  - No bit is corrupted.
- WRITE 0x80 where another master pulls SDA low on bit 1:
  - Both lines are released the next cycle.
  - rsp_arb=1, bus_owned=0.
- WRITE while not owned:
  - rsp_valid one cycle after acceptance with rsp_err=1.
  - scl_oe and sda_oe stay 0 throughout.
- RST_I asserted mid-READ:
  - scl_oe=0 and sda_oe=0 in the same cycle (asynchronous).
  - After release: cmd_ready=1, bus_owned=0, no rsp_valid.
